pq_cmd_driver: RTL and testbench
================================

# pq_cmd_driver

Command initiator for the priority-queue command interface (`i_wrt`/`i_read`/`i_data`, `o_full`/`o_empty`/`o_data`) used by the queue blocks. It accepts push, pop and replace commands from an upstream valid/ready stream. It issues each command as a single-cycle pulse to the queue, waits until the queue has settled, and returns popped values on a downstream valid/ready stream. It also keeps a shadow occupancy count and sticky error flags, so producers never drive the queue out of protocol.

## Interface
- `DATA_WIDTH`, 16, key/data width.
- `QUEUE_SIZE`, 4, capacity of the attached queue; bounds the shadow count.
- `SETTLE_CYCLES`, 1, minimum WAIT cycles after each issue (≥1).
- `CLK`  in  1  clock; all logic on rising edge.
- `RSTn`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  upstream command valid.
- `s_ready`  out  1  upstream command ready.
- `s_op`  in  2  00 nop, 01 push, 10 pop, 11 replace.
- `s_data`  in  DATA_WIDTH  push/replace data.
- `m_valid`  out  1  popped value valid.
- `m_ready`  in  1  downstream ready.
- `m_data`  out  DATA_WIDTH  popped value.
- `pq_wrt`, `pq_read`  out  1 each  queue command pulses.
- `pq_data`  out  DATA_WIDTH  queue write data.
- `pq_full`, `pq_empty`  in  1 each  queue flags.
- `pq_valid`  in  1  queue able to take a command; tie high if the queue has none.
- `pq_odata`  in  DATA_WIDTH  queue top-of-queue value.
- `o_count`  out  $clog2(QUEUE_SIZE+1)  shadow occupancy.
- `o_err`  out  2  sticky errors: bit0 overflow, bit1 underflow.
- `i_err_clr`  in  1  clears `o_err`.

## Operation
- FSM states:
  - IDLE: `s_ready`=1.
  - ISSUE: one cycle; drives `pq_wrt`/`pq_read`/`pq_data` from registered command.
  - WAIT: settle counter.
  - RESP: `m_valid`=1, held until `m_ready`.
- IDLE, on accept (`s_valid`&&`s_ready`):
  - nop: stay IDLE.
  - push with `o_count`==QUEUE_SIZE or `pq_full`: dropped, set `o_err[0]`, stay IDLE.
  - pop with `o_count`==0 or `pq_empty`: dropped, set `o_err[1]`, stay IDLE.
  - otherwise latch op/data, go to ISSUE.
- ISSUE pulses:
  - push: `pq_wrt`=1.
  - pop: `pq_read`=1.
  - replace: both =1.
  - replace with `o_count`==0 is issued as push (`pq_wrt` only) and produces no response.
- ISSUE to WAIT: pop/replace capture `pq_odata` into `m_data` at the ISSUE edge. This is the pre-operation top, i.e. the removed item.
- WAIT: counter loaded with SETTLE_CYCLES at ISSUE and decremented each cycle. Exit when counter reaches 0 and `pq_valid`=1:
  - pop/replace: to RESP.
  - push: to IDLE.
- RESP to IDLE on `m_ready`. `m_data` is stable while `m_valid`=1.
- Shadow count updates at the ISSUE edge:
  - push +1; pop −1.
  - replace: unchanged, except +1 when count was 0.
  - Never leaves 0..QUEUE_SIZE.
- `o_err` bits are set only by drops. `i_err_clr` has priority over a same-cycle set.
- `pq_wrt`/`pq_read` are 0 in every state except ISSUE; `pq_data` holds its last value.

## Timing
- Reset values:
  - state IDLE.
  - `s_ready` 1 once reset is released.
  - `m_valid` 0, `m_data` 0.
  - `pq_wrt`/`pq_read` 0, `pq_data` 0.
  - `o_count` 0, `o_err` 0.
- Pop (SETTLE_CYCLES=1, `pq_valid`=1, `m_ready`=1), with accept in cycle 0:
  - cycle 1: ISSUE, `pq_read`=1.
  - cycle 2: WAIT.
  - cycle 3: `m_valid`=1.
  - cycle 4: `s_ready`=1.
- Push, same conditions: ISSUE in cycle 1, WAIT in cycle 2, `s_ready`=1 in cycle 3.
- `pq_valid` low in WAIT extends WAIT one cycle per low cycle. `m_ready` low extends RESP.
- Drops and nops occupy no extra cycle: `s_ready` stays 1 and back-to-back accepts are allowed.
- Reset asserted mid-command aborts immediately: pulses go low the same instant, no response is produced and the count returns to 0.

## Configuration
- `PQ_CMD_DRIVER_STATS_EN` defined: adds outputs `o_push_cnt` and `o_pop_cnt` (32-bit each, reset 0, wrap at 2^32).
  - `o_push_cnt` increments on each issued push.
  - `o_pop_cnt` increments on each issued pop or replace.
- Undefined: these ports and their counters do not exist.

## Test plan
- Push 5, 9, 3, then pop ×3 with a queue model returning the max: `m_data` = 9, 5, 3; `o_count` 3→0; `o_err`=0.
- Pop at `o_count`=0: no `pq_read` pulse, `m_valid` stays 0, `o_err`=2'b10; then `i_err_clr` → 0.
- QUEUE_SIZE=4: push ×5 → 4 `pq_wrt` pulses, `o_err[0]`=1, `o_count`=4.
- Replace 7 on empty: only `pq_wrt` pulsed, no `m_valid`, `o_count`=1. Then replace 2 on a queue holding 7: `m_data`=7, `o_count`=1.
- Pop with `pq_valid` held low 3 cycles and `m_ready` low 2 cycles: `m_valid` is delayed exactly 3 cycles and held 3 cycles; `s_ready` is 0 throughout.
- `RSTn` pulsed during WAIT of a pop: `m_valid` never rises, all outputs return to reset values, and `s_ready`=1 after release.

Source files
------------

// File: rtl/pq_cmd_driver.sv
// pq_cmd_driver: command initiator for a priority-queue block.
// Accepts push/pop/replace from an upstream valid/ready stream, issues each
// command as a single-cycle pulse, waits for the queue to settle and returns
// the removed item on a downstream valid/ready stream. Keeps a shadow
// occupancy count and sticky overflow/underflow flags.
// Optional feature: define PQ_CMD_DRIVER_STATS_EN to add 32-bit push/pop
// issue counters (o_push_cnt, o_pop_cnt).
module pq_cmd_driver #(
  parameter int DATA_WIDTH    = 16,
  parameter int QUEUE_SIZE    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                            CLK,
  input  logic                            RSTn,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [1:0]                      s_op,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            pq_wrt,
  output logic                            pq_read,
  output logic [DATA_WIDTH-1:0]           pq_data,
  input  logic                            pq_full,
  input  logic                            pq_empty,
  input  logic                            pq_valid,
  input  logic [DATA_WIDTH-1:0]           pq_odata,
  output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
  output logic [1:0]                      o_err,
  input  logic                            i_err_clr
`ifdef PQ_CMD_DRIVER_STATS_EN
  ,
  output logic [31:0]                     o_push_cnt,
  output logic [31:0]                     o_pop_cnt
`endif
);

  localparam int CW = $clog2(QUEUE_SIZE + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  // Op encoding: bit0 drives pq_wrt, bit1 drives pq_read.
  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [1:0]              op_r, op_s;
  logic [SW-1:0]           settle_r;
  logic [CW-1:0]           count_r;
  logic [1:0]              err_r, err_s;
  logic [DATA_WIDTH-1:0]   pq_data_r;
  logic [DATA_WIDTH-1:0]   m_data_r;
  logic                    s_ready_r, m_valid_r, pq_wrt_r, pq_read_r;
  logic                    s_ready_s, m_valid_s, pq_wrt_s, pq_read_s;
  logic                    accept_s, push_drop_s, pop_drop_s, go_issue_s;
  logic                    at_full_s, at_empty_s, wait_done_s;

  // Decode an accepted command into drop / issue decisions and the op to latch.
  always_comb begin
    at_full_s   = (count_r == CW'(QUEUE_SIZE)) || pq_full;
    at_empty_s  = (count_r == {CW{1'b0}}) || pq_empty;
    accept_s    = s_valid && (state_r == ST_IDLE);
    push_drop_s = 1'b0;
    pop_drop_s  = 1'b0;
    go_issue_s  = 1'b0;
    op_s        = op_r;
    if (accept_s) begin
      case (s_op)
        OP_PUSH: begin
          if (at_full_s) begin
            push_drop_s = 1'b1;
          end else begin
            go_issue_s = 1'b1;
            op_s       = OP_PUSH;
          end
        end
        OP_POP: begin
          if (at_empty_s) begin
            pop_drop_s = 1'b1;
          end else begin
            go_issue_s = 1'b1;
            op_s       = OP_POP;
          end
        end
        OP_REPL: begin
          go_issue_s = 1'b1;
          // Replacing into an empty queue is just an insertion; nothing is removed.
          if (count_r == {CW{1'b0}}) begin
            op_s = OP_PUSH;
          end else begin
            op_s = OP_REPL;
          end
        end
        OP_NOP:  go_issue_s = 1'b0;
        default: go_issue_s = 1'b0;
      endcase
    end else begin
      go_issue_s = 1'b0;
    end
  end

  // Settle done once the minimum wait has elapsed and the queue reports ready.
  always_comb begin
    wait_done_s = (settle_r <= SW'(1)) && pq_valid;
  end

  // Sticky error flags; clear wins over a same-cycle drop.
  always_comb begin
    if (i_err_clr) begin
      err_s = 2'b00;
    end else begin
      err_s = err_r | {pop_drop_s, push_drop_s};
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_issue_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (wait_done_s) begin
          state_s = op_r[1] ? ST_RESP : ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (m_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the outputs can be registered.
  always_comb begin
    s_ready_s = (state_s == ST_IDLE);
    m_valid_s = (state_s == ST_RESP);
    pq_wrt_s  = go_issue_s && op_s[0];
    pq_read_s = go_issue_s && op_s[1];
  end

  // Registered handshake and queue pulse outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      pq_wrt_r  <= 1'b0;
      pq_read_r <= 1'b0;
    end else begin
      s_ready_r <= s_ready_s;
      m_valid_r <= m_valid_s;
      pq_wrt_r  <= pq_wrt_s;
      pq_read_r <= pq_read_s;
    end
  end

  // Command latch, write data, captured top-of-queue, shadow count, settle timer, errors.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      op_r      <= OP_NOP;
      pq_data_r <= {DATA_WIDTH{1'b0}};
      m_data_r  <= {DATA_WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      settle_r  <= {SW{1'b0}};
      err_r     <= 2'b00;
    end else begin
      op_r  <= op_s;
      err_r <= err_s;
      if (go_issue_s && op_s[0]) begin
        pq_data_r <= s_data;
      end
      if (state_r == ST_ISSUE) begin
        settle_r <= SW'(SETTLE_CYCLES);
        // The pre-operation top is the item being removed.
        if (op_r[1]) begin
          m_data_r <= pq_odata;
        end
        case (op_r)
          OP_PUSH: begin
            if (count_r != CW'(QUEUE_SIZE)) begin
              count_r <= count_r + CW'(1);
            end
          end
          OP_POP: begin
            if (count_r != {CW{1'b0}}) begin
              count_r <= count_r - CW'(1);
            end
          end
          default: count_r <= count_r;
        endcase
      end else if ((state_r == ST_WAIT) && (settle_r != {SW{1'b0}})) begin
        settle_r <= settle_r - SW'(1);
      end
    end
  end

`ifdef PQ_CMD_DRIVER_STATS_EN
  logic [31:0] push_cnt_r, pop_cnt_r;

  // Issue statistics, counted at the issue edge and wrapping naturally.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      push_cnt_r <= 32'd0;
      pop_cnt_r  <= 32'd0;
    end else if (state_r == ST_ISSUE) begin
      if (op_r == OP_PUSH) begin
        push_cnt_r <= push_cnt_r + 32'd1;
      end
      if (op_r[1]) begin
        pop_cnt_r <= pop_cnt_r + 32'd1;
      end
    end
  end

  assign o_push_cnt = push_cnt_r;
  assign o_pop_cnt  = pop_cnt_r;
`endif

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign pq_wrt  = pq_wrt_r;
  assign pq_read = pq_read_r;
  assign pq_data = pq_data_r;
  assign o_count = count_r;
  assign o_err   = err_r;

endmodule

// File: tb/tb_pq_cmd_driver.sv
// Directed testbench for pq_cmd_driver with a small max-priority queue model.
module tb_pq_cmd_driver;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        s_valid, s_ready;
  logic [1:0]  s_op;
  logic [15:0] s_data;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        pq_wrt, pq_read;
  logic [15:0] pq_data;
  logic        pq_full, pq_empty, pq_valid;
  logic [15:0] pq_odata;
  logic [2:0]  o_count;
  logic [1:0]  o_err;
  logic        i_err_clr;
`ifdef PQ_CMD_DRIVER_STATS_EN
  logic [31:0] o_push_cnt, o_pop_cnt;
`endif

  int n_err = 0;
  int n_chk = 0;

  int wrt_n  = 0;
  int rd_n   = 0;
  int resp_n = 0;
  int mv_n   = 0;
  logic [15:0] popped[$];

  logic [15:0] mem [0:7];
  int          mdl_n;
  int          top_i;

  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] REPL = 2'b11;

  pq_cmd_driver #(.DATA_WIDTH(16), .QUEUE_SIZE(4), .SETTLE_CYCLES(1)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .s_valid(s_valid), .s_ready(s_ready), .s_op(s_op), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .pq_wrt(pq_wrt), .pq_read(pq_read), .pq_data(pq_data),
    .pq_full(pq_full), .pq_empty(pq_empty), .pq_valid(pq_valid),
    .pq_odata(pq_odata),
    .o_count(o_count), .o_err(o_err), .i_err_clr(i_err_clr)
`ifdef PQ_CMD_DRIVER_STATS_EN
    , .o_push_cnt(o_push_cnt), .o_pop_cnt(o_pop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Queue model: top of queue is the maximum stored value.
  always_comb begin
    top_i = 0;
    for (int i = 1; i < 8; i++) begin
      if (i < mdl_n && mem[i] > mem[top_i]) top_i = i;
    end
  end
  assign pq_odata = (mdl_n > 0) ? mem[top_i] : 16'h0000;
  assign pq_full  = (mdl_n >= 4);
  assign pq_empty = (mdl_n == 0);

  // Queue model update on command pulses.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mdl_n <= 0;
    end else if (pq_wrt && pq_read && mdl_n > 0) begin
      mem[top_i] <= pq_data;
    end else if (pq_read && mdl_n > 0) begin
      mem[top_i] <= mem[mdl_n-1];
      mdl_n      <= mdl_n - 1;
    end else if (pq_wrt && mdl_n < 8) begin
      mem[mdl_n] <= pq_data;
      mdl_n      <= mdl_n + 1;
    end
  end

  // Activity monitor: pulse counts and delivered responses.
  always @(posedge CLK) begin
    if (pq_wrt)  wrt_n <= wrt_n + 1;
    if (pq_read) rd_n  <= rd_n + 1;
    if (m_valid) mv_n  <= mv_n + 1;
    if (m_valid && m_ready) begin
      resp_n <= resp_n + 1;
      popped.push_back(m_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d);
    int n;
    s_valid = 1'b1; s_op = op; s_data = d;
    step();
    s_valid = 1'b0; s_op = 2'b00;
    n = 0;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic err_clear();
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
  endtask

  int w0, r0, rs0, mv0;

  initial begin
    RSTn = 1'b0; s_valid = 1'b0; s_op = 2'b00; s_data = 16'h0;
    m_ready = 1'b1; pq_valid = 1'b1; i_err_clr = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_pq_wrt", pq_wrt, 0);
    chk("rst_pq_read", pq_read, 0);
    chk("rst_pq_data", pq_data, 0);
    chk("rst_count", o_count, 0);
    chk("rst_err", o_err, 0);
    step();

    // Push 5, 9, 3 then pop three times: max first.
    send(PUSH, 16'd5); send(PUSH, 16'd9); send(PUSH, 16'd3);
    chk("push3_count", o_count, 3);
    chk("push3_wrt", wrt_n, 3);
    s_valid = 1'b1; s_op = POP;
    step();
    s_valid = 1'b0; s_op = 2'b00;
    chk("pop_c1_read", pq_read, 1);
    chk("pop_c1_sready", s_ready, 0);
    step();
    chk("pop_c2_read", pq_read, 0);
    chk("pop_c2_mvalid", m_valid, 0);
    step();
    chk("pop_c3_mvalid", m_valid, 1);
    chk("pop_c3_mdata", m_data, 9);
    step();
    chk("pop_c4_sready", s_ready, 1);
    chk("pop_c4_mvalid", m_valid, 0);
    send(POP, 16'd0); send(POP, 16'd0);
    chk("pop3_n", popped.size(), 3);
    chk("pop3_v1", popped[1], 5);
    chk("pop3_v2", popped[2], 3);
    chk("pop3_count", o_count, 0);
    chk("pop3_err", o_err, 0);

    // Underflow drop.
    r0 = rd_n; rs0 = resp_n; mv0 = mv_n;
    send(POP, 16'd0);
    chk("uf_sready", s_ready, 1);
    step(); step();
    chk("uf_read", rd_n - r0, 0);
    chk("uf_resp", resp_n - rs0, 0);
    chk("uf_mvalid", mv_n - mv0, 0);
    chk("uf_err", o_err, 2'b10);
    err_clear();
    chk("uf_clr", o_err, 0);

    // Overflow drop.
    w0 = wrt_n;
    for (int i = 1; i <= 5; i++) send(PUSH, 16'(i));
    chk("of_wrt", wrt_n - w0, 4);
    chk("of_err", o_err, 2'b01);
    chk("of_count", o_count, 4);
    err_clear();
    chk("of_clr", o_err, 0);
    for (int i = 0; i < 4; i++) send(POP, 16'd0);
    chk("of_pop_a", popped[3], 4);
    chk("of_pop_b", popped[4], 3);
    chk("of_pop_c", popped[5], 2);
    chk("of_pop_d", popped[6], 1);
    chk("of_count0", o_count, 0);

    // Replace on empty, then replace on one item.
    w0 = wrt_n; r0 = rd_n; rs0 = resp_n;
    send(REPL, 16'd7);
    chk("rep0_wrt", wrt_n - w0, 1);
    chk("rep0_read", rd_n - r0, 0);
    chk("rep0_resp", resp_n - rs0, 0);
    chk("rep0_count", o_count, 1);
    send(REPL, 16'd2);
    chk("rep1_resp", resp_n - rs0, 1);
    chk("rep1_data", popped[7], 7);
    chk("rep1_read", rd_n - r0, 1);
    chk("rep1_count", o_count, 1);
    chk("rep1_pqdata", pq_data, 2);

    // Pop with pq_valid low 3 WAIT cycles and m_ready low 2 RESP cycles.
    pq_valid = 1'b0; m_ready = 1'b0;
    s_valid = 1'b1; s_op = POP;
    for (int c = 1; c <= 9; c++) begin
      step();
      s_valid = 1'b0; s_op = 2'b00;
      pq_valid = (c <= 4) ? 1'b0 : 1'b1;
      m_ready  = (c <= 7) ? 1'b0 : 1'b1;
      chk($sformatf("stall_mv_c%0d", c), m_valid, (c >= 6 && c <= 8) ? 1 : 0);
      chk($sformatf("stall_sr_c%0d", c), s_ready, (c == 9) ? 1 : 0);
    end
    pq_valid = 1'b1; m_ready = 1'b1;
    chk("stall_data", popped[8], 2);
    chk("stall_count", o_count, 0);

    // Reset during WAIT of a pop.
    send(PUSH, 16'd11);
    rs0 = resp_n; mv0 = mv_n;
    s_valid = 1'b1; s_op = POP;
    step();
    s_valid = 1'b0; s_op = 2'b00;
    chk("ra_issue", pq_read, 1);
    step();
    RSTn = 1'b0;
    #1;
    chk("ra_mvalid", m_valid, 0);
    chk("ra_read", pq_read, 0);
    chk("ra_wrt", pq_wrt, 0);
    chk("ra_mdata", m_data, 0);
    chk("ra_pqdata", pq_data, 0);
    chk("ra_count", o_count, 0);
    chk("ra_err", o_err, 0);
    step(); step();
    RSTn = 1'b1;
    step();
    chk("ra_sready", s_ready, 1);
    chk("ra_mv_never", mv_n - mv0, 0);
    chk("ra_resp", resp_n - rs0, 0);
    send(PUSH, 16'd6); send(POP, 16'd0);
    chk("ra_after", popped[9], 6);
    chk("ra_after_count", o_count, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
